stb_dcache_wr_resp: RTL

Cache-side responder for the store-buffer drain interface. It accepts one buffered store at a time from the store buffer, performs the tag lookup, and merges the bytes into its data array on a hit. The store is always written through to the memory bus; misses do not allocate. Once memory confirms the write, it returns the single-cycle write acknowledge the store buffer waits on before advancing its read pointer.

---
 rtl/stb_dcache_wr_resp.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/stb_dcache_wr_resp.sv
// Write-through store responder: one buffered store at a time, tag lookup,
// bytewise merge on hit, memory write, then a single-cycle ack to the store buffer.
module stb_dcache_wr_resp #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb2dc_req_i,
  input  logic [31:0] stb2dc_addr_i,
  input  logic [31:0] stb2dc_data_i,
  input  logic [3:0]  stb2dc_sel_i,
  output logic        dc2stb_ack_o,
  output logic        dc2stb_busy_o,
  output logic        dc2mem_req_o,
  output logic [31:0] dc2mem_addr_o,
  output logic [31:0] dc2mem_data_o,
  output logic [3:0]  dc2mem_sel_o,
  input  logic        mem2dc_ack_i,
  input  logic        refill_valid_i,
  input  logic [31:0] refill_addr_i,
  input  logic [31:0] refill_data_i,
  output logic        refill_ready_o,
  input  logic        flush_i,
  output logic [15:0] hit_cnt_o,
  output logic [15:0] miss_cnt_o
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, MEM_WR, ACK} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, data_q;
  logic [3:0]        sel_q;
  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [31:0]       data_mem [DEPTH];
  logic [15:0]       hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]  idx, ridx;
  logic [TAG_W-1:0]  req_tag, rtag;
  logic              hit, lookup, refill_fire;
  logic [31:0]       merged;
  logic              unused_addr_bits;

  assign idx     = addr_q[IDX_W+1:2];
  assign req_tag = addr_q[31:IDX_W+2];
  assign ridx    = refill_addr_i[IDX_W+1:2];
  assign rtag    = refill_addr_i[31:IDX_W+2];
  assign unused_addr_bits = ^{stb2dc_addr_i[1:0], refill_addr_i[1:0]};

  assign lookup      = (state_q == LOOKUP);
  assign hit         = valid_q[idx] && (tag_mem[idx] == req_tag);
  assign refill_fire = refill_valid_i && refill_ready_o;

  always_comb begin
    merged = data_mem[idx];
    for (int unsigned b = 0; b < 4; b++) begin
      if (sel_q[b]) merged[8*b +: 8] = data_q[8*b +: 8];
    end
  end

  always_comb begin
    state_d        = state_q;
    dc2stb_ack_o   = 1'b0;
    dc2stb_busy_o  = 1'b1;
    dc2mem_req_o   = 1'b0;
    refill_ready_o = 1'b1;
    unique case (state_q)
      IDLE: begin
        dc2stb_busy_o = 1'b0;
        if (stb2dc_req_i) state_d = LOOKUP;
      end
      LOOKUP: begin
        refill_ready_o = 1'b0;
        state_d        = MEM_WR;
      end
      MEM_WR: begin
        dc2mem_req_o = 1'b1;
        if (mem2dc_ack_i) state_d = ACK;
      end
      ACK: begin
        dc2stb_ack_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
      sel_q  <= '0;
    end else if (state_q == IDLE && stb2dc_req_i) begin
      addr_q <= {stb2dc_addr_i[31:2], 2'b00};
      data_q <= stb2dc_data_i;
      sel_q  <= stb2dc_sel_i;
    end
  end

  // Flush wins over a same-cycle refill; the refill is still handshaken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           valid_q <= '0;
    else if (flush_i)     valid_q <= '0;
    else if (refill_fire) valid_q[ridx] <= 1'b1;
  end

  // Refill never coincides with LOOKUP, so the two writers cannot collide.
  always_ff @(posedge clk) begin
    if (refill_fire) begin
      tag_mem[ridx]  <= rtag;
      data_mem[ridx] <= refill_data_i;
    end else if (lookup && hit) begin
      data_mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (lookup) begin
      if (hit && hit_cnt_q != '1)        hit_cnt_q  <= hit_cnt_q + 16'd1;
      else if (!hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign dc2mem_addr_o = addr_q;
  assign dc2mem_data_o = data_q;
  assign dc2mem_sel_o  = sel_q;
  assign hit_cnt_o     = hit_cnt_q;
  assign miss_cnt_o    = miss_cnt_q;

endmodule
